rv32e_idu: RTL and testbench

- Registered RV32E instruction decode stage with a valid/ready handshake on both sides.
- Accepts a fetched instruction and its PC, and produces a one-entry output register holding everything the execute stage needs.
- Outputs include the 4-bit ALU operation code, operand selects, the sign-extended immediate, register indices and control flags.
- Sits between the IFU and the EXU; its alu_op output drives the ALU opcode input directly.

---
 rtl/rv32e_idu.sv | 197 +++++++++++++++++++
 tb/tb_rv32e_idu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rv32e_idu.sv
// rtl/rv32e_idu.sv - registered RV32E instruction decode stage with valid/ready handshake
module rv32e_idu #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_TAG = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      alu_op,
    output logic [1:0]      src1_sel,
    output logic            src2_sel,
    output logic [31:0]     imm,
    output logic [3:0]      rs1,
    output logic [3:0]      rs2,
    output logic [3:0]      rd,
    output logic            rd_wen,
    output logic            mem_ren,
    output logic            mem_wen,
    output logic [2:0]      funct3,
    output logic            branch,
    output logic            jal,
    output logic            jalr,
    output logic            ebreak,
    output logic            illegal
);
    typedef struct packed {
        logic [3:0]  alu_op;
        logic [1:0]  src1_sel;
        logic        src2_sel;
        logic [31:0] imm;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic        rd_wen;
        logic        mem_ren;
        logic        mem_wen;
        logic [2:0]  funct3;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        ebreak;
        logic        illegal;
    } dec_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct3 to ALU code; alt selects SUB/SRA where the caller allows it
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? 4'd1 : 4'd0;
            3'b001:  return 4'd2;
            3'b010:  return 4'd3;
            3'b011:  return 4'd4;
            3'b100:  return 4'd5;
            3'b101:  return alt ? 4'd7 : 4'd6;
            3'b110:  return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        use_rs1, use_rs2, use_rd, wen, bad;
    dec_t        d, q;
    logic        valid_q;
    logic [XLEN-1:0] pc_q;

    assign opc   = in_inst[6:0];
    assign f3    = in_inst[14:12];
    assign f7    = in_inst[31:25];
    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Combinational decode of the incoming instruction word
    always_comb begin
        d       = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        wen     = 1'b0;
        bad     = 1'b0;
        d.rs1    = in_inst[18:15];
        d.rs2    = in_inst[23:20];
        d.rd     = in_inst[10:7];
        d.funct3 = f3;
        case (opc)
            OPC_LUI:   begin d.src1_sel = 2'd2; d.src2_sel = 1'b1; d.imm = imm_u; use_rd = 1'b1; end
            OPC_AUIPC: begin d.src1_sel = 2'd1; d.src2_sel = 1'b1; d.imm = imm_u; use_rd = 1'b1; end
            OPC_JAL:   begin d.src1_sel = 2'd1; d.src2_sel = 1'b1; d.imm = imm_j; use_rd = 1'b1; d.jal = 1'b1; end
            OPC_JALR: begin
                d.src2_sel = 1'b1; d.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1; d.jalr = 1'b1;
                bad = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                d.imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; d.branch = 1'b1;
                d.alu_op = (f3[2:1] == 2'b00) ? 4'd1 : (f3[1] ? 4'd4 : 4'd3);
                bad = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                d.src2_sel = 1'b1; d.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1; d.mem_ren = 1'b1;
                bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                d.src2_sel = 1'b1; d.imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; d.mem_wen = 1'b1;
                bad = (f3 > 3'b010);
            end
            OPC_OPIMM: begin
                d.src2_sel = 1'b1; d.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
                d.alu_op = alu_from_f3(f3, f7[5] && (f3 == 3'b101));
                if (f3 == 3'b001)
                    bad = (f7 != 7'b0000000);
                else if (f3 == 3'b101)
                    bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
            end
            OPC_OP: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                d.alu_op = alu_from_f3(f3, f7[5]);
                bad = !((f7 == 7'b0000000) || ((f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_SYSTEM: begin
                d.ebreak = (in_inst == 32'h0010_0073);
                bad      = !d.ebreak;
            end
            default: bad = 1'b1;
        endcase
        wen = use_rd;
        // RV32E has 16 registers: any referenced index with bit 4 set is illegal
        if (in_inst[1:0] != 2'b11 || (use_rs1 && in_inst[19]) || (use_rs2 && in_inst[24]) || (use_rd && in_inst[11]))
            bad = 1'b1;
        d.illegal = bad;
        d.rd_wen  = wen && !bad && (in_inst[11:7] != 5'd0);
        d.mem_ren = d.mem_ren && !bad;
        d.mem_wen = d.mem_wen && !bad;
        d.branch  = d.branch && !bad;
        d.jal     = d.jal && !bad;
        d.jalr    = d.jalr && !bad;
    end

    assign in_ready = (!valid_q || out_ready) && !flush;

    // Output register: flush beats capture, capture beats drain, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC_TAG;
            q       <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            pc_q    <= in_pc;
            q       <= d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = valid_q ? pc_q : RESET_PC_TAG;
    assign alu_op    = q.alu_op;
    assign src1_sel  = q.src1_sel;
    assign src2_sel  = q.src2_sel;
    assign imm       = q.imm;
    assign rs1       = q.rs1;
    assign rs2       = q.rs2;
    assign rd        = q.rd;
    assign rd_wen    = q.rd_wen;
    assign mem_ren   = q.mem_ren;
    assign mem_wen   = q.mem_wen;
    assign funct3    = q.funct3;
    assign branch    = q.branch;
    assign jal       = q.jal;
    assign jalr      = q.jalr;
    assign ebreak    = q.ebreak;
    assign illegal   = q.illegal;
endmodule

// File: tb/tb_rv32e_idu.sv
// tb/tb_rv32e_idu.sv - directed self-checking bench for rv32e_idu
module tb_rv32e_idu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [3:0]  alu_op;
    logic [1:0]  src1_sel;
    logic        src2_sel;
    logic [31:0] imm;
    logic [3:0]  rs1, rs2, rd;
    logic        rd_wen, mem_ren, mem_wen;
    logic [2:0]  funct3;
    logic        branch, jal, jalr, ebreak, illegal;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_SUB  = 32'h407302B3;
    localparam logic [31:0] I_ADDI = 32'hFFF00093;
    localparam logic [31:0] I_LUI  = 32'h123451B7;

    rv32e_idu dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .alu_op(alu_op), .src1_sel(src1_sel), .src2_sel(src2_sel), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rd_wen(rd_wen), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .funct3(funct3), .branch(branch), .jal(jal), .jalr(jalr), .ebreak(ebreak), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        checks++; if (out_pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc got %h exp 80000000", out_pc); end
        checks++; if (alu_op !== 4'd0 || imm !== 32'h0 || rd_wen !== 1'b0) begin errors++; $display("FAIL reset_fields got alu=%0d imm=%h wen=%b exp 0/0/0", alu_op, imm, rd_wen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_alu_decode;
        @(negedge clk); drive(I_ADD, 32'h100);
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin errors++; $display("FAIL add_valid got v=%b pc=%h exp 1/100", out_valid, out_pc); end
        checks++; if ({alu_op, rs1, rs2, rd} !== {4'd0, 4'd2, 4'd3, 4'd1}) begin errors++; $display("FAIL add_fields got %h exp 0231", {alu_op, rs1, rs2, rd}); end
        checks++; if ({src2_sel, rd_wen, illegal} !== 3'b010) begin errors++; $display("FAIL add_flags got %b exp 010", {src2_sel, rd_wen, illegal}); end
        drive(I_SUB, 32'h104);
        @(negedge clk); in_valid = 1'b0;
        checks++; if (alu_op !== 4'd1 || rd !== 4'd5) begin errors++; $display("FAIL sub got alu=%0d rd=%0d exp 1/5", alu_op, rd); end
        drive(I_ADDI, 32'h108);
        @(negedge clk); in_valid = 1'b0;
        checks++; if ({alu_op, src2_sel} !== {4'd0, 1'b1} || imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi got alu=%0d s2=%b imm=%h exp 0/1/ffffffff", alu_op, src2_sel, imm); end
        drive(I_LUI, 32'h10C);
        @(negedge clk); in_valid = 1'b0;
        checks++; if ({src1_sel, src2_sel, rd_wen} !== 4'b1011 || imm !== 32'h12345000 || rd !== 4'd3) begin errors++; $display("FAIL lui got s1=%0d s2=%b wen=%b imm=%h rd=%0d exp 2/1/1/12345000/3", src1_sel, src2_sel, rd_wen, imm, rd); end
        drive(32'h4030D093, 32'h110);
        @(negedge clk); in_valid = 1'b0;
        checks++; if (alu_op !== 4'd7 || illegal !== 1'b0) begin errors++; $display("FAIL srai got alu=%0d ill=%b exp 7/0", alu_op, illegal); end
        drive(32'h40309093, 32'h114);
        @(negedge clk); in_valid = 1'b0;
        checks++; if (illegal !== 1'b1 || rd_wen !== 1'b0) begin errors++; $display("FAIL bad_slli got ill=%b wen=%b exp 1/0", illegal, rd_wen); end
        drive(32'h00000013, 32'h118);
        @(negedge clk); in_valid = 1'b0;
        checks++; if (rd_wen !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL nop_rd0 got wen=%b ill=%b exp 0/0", rd_wen, illegal); end
    endtask

    task automatic test_control_flow;
        drive(32'h0020C463, 32'h200);
        @(negedge clk); in_valid = 1'b0;
        checks++; if (alu_op !== 4'd3 || branch !== 1'b1 || imm !== 32'd8) begin errors++; $display("FAIL blt got alu=%0d br=%b imm=%h exp 3/1/8", alu_op, branch, imm); end
        checks++; if (rd_wen !== 1'b0 || funct3 !== 3'b100 || src2_sel !== 1'b0 || rs1 !== 4'd1 || rs2 !== 4'd2) begin errors++; $display("FAIL blt_misc got wen=%b f3=%b s2=%b rs1=%0d rs2=%0d exp 0/100/0/1/2", rd_wen, funct3, src2_sel, rs1, rs2); end
        drive(32'h0020A223, 32'h204);
        @(negedge clk); in_valid = 1'b0;
        checks++; if ({mem_wen, mem_ren, rd_wen, src2_sel} !== 4'b1001 || imm !== 32'd4 || funct3 !== 3'b010) begin errors++; $display("FAIL sw got flags=%b imm=%h f3=%b exp 1001/4/010", {mem_wen, mem_ren, rd_wen, src2_sel}, imm, funct3); end
        drive(32'hFFDFF0EF, 32'h208);
        @(negedge clk); in_valid = 1'b0;
        checks++; if ({jal, rd_wen, src2_sel} !== 3'b111 || src1_sel !== 2'd1 || imm !== 32'hFFFFFFFC) begin errors++; $display("FAIL jal got flags=%b s1=%0d imm=%h exp 111/1/fffffffc", {jal, rd_wen, src2_sel}, src1_sel, imm); end
    endtask

    task automatic test_rv32e_system;
        drive(32'h00000833, 32'h300);
        @(negedge clk); in_valid = 1'b0;
        checks++; if (illegal !== 1'b1 || rd_wen !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL x16 got ill=%b wen=%b v=%b exp 1/0/1", illegal, rd_wen, out_valid); end
        drive(32'h00100073, 32'h304);
        @(negedge clk); in_valid = 1'b0;
        checks++; if (ebreak !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL ebreak got eb=%b ill=%b exp 1/0", ebreak, illegal); end
        drive(32'h00000073, 32'h308);
        @(negedge clk); in_valid = 1'b0;
        checks++; if (ebreak !== 1'b0 || illegal !== 1'b1) begin errors++; $display("FAIL ecall got eb=%b ill=%b exp 0/1", ebreak, illegal); end
        drive(32'h00000000, 32'h30C);
        @(negedge clk); in_valid = 1'b0;
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL zero_word got ill=%b exp 1", illegal); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] insts [3];
        logic [3:0]  rds [3];
        insts[0] = I_ADD; insts[1] = I_SUB; insts[2] = I_LUI;
        rds[0] = 4'd1; rds[1] = 4'd5; rds[2] = 4'd3;
        drive(insts[0], 32'h400);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) drive(insts[i+1], 32'h400 + 32'(4 * (i + 1)));
            else in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1 || rd !== rds[i] || out_pc !== 32'h400 + 32'(4 * i)) begin errors++; $display("FAIL b2b_%0d got v=%b rd=%0d pc=%h exp 1/%0d/%h", i, out_valid, rd, out_pc, rds[i], 32'h400 + 32'(4 * i)); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h8000_0000) begin errors++; $display("FAIL drain got v=%b pc=%h exp 0/80000000", out_valid, out_pc); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        drive(I_ADD, 32'h500);
        @(negedge clk);
        drive(I_SUB, 32'h504);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || rd !== 4'd1 || alu_op !== 4'd0 || out_pc !== 32'h500) begin errors++; $display("FAIL hold_%0d got rdy=%b v=%b rd=%0d alu=%0d pc=%h exp 0/1/1/0/500", i, in_ready, out_valid, rd, alu_op, out_pc); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", in_ready); end
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || rd !== 4'd5 || alu_op !== 4'd1 || out_pc !== 32'h504) begin errors++; $display("FAIL release_capture got v=%b rd=%0d alu=%0d pc=%h exp 1/5/1/504", out_valid, rd, alu_op, out_pc); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        flush = 1'b1;
        drive(I_ADDI, 32'h600);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", in_ready); end
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h8000_0000) begin errors++; $display("FAIL flush_kill got v=%b pc=%h exp 0/80000000", out_valid, out_pc); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_capture got v=%b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(I_SUB, 32'h700);
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || alu_op !== 4'd1) begin errors++; $display("FAIL pre_rst got v=%b alu=%0d exp 1/1", out_valid, alu_op); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h8000_0000 || alu_op !== 4'd0 || rd !== 4'd0) begin errors++; $display("FAIL async_rst got v=%b pc=%h alu=%0d rd=%0d exp 0/80000000/0/0", out_valid, out_pc, alu_op, rd); end
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset;
        test_alu_decode;
        test_control_flow;
        test_rv32e_system;
        test_back_to_back;
        test_backpressure;
        test_flush;
        test_reset_mid;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
